// File: rtl/bht_clear_sequencer.sv
// bht_clear_sequencer: owns the BHT write port, walking all entries to INIT_STATE after reset or on request
module bht_clear_sequencer #(
  parameter int k = 10,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ClearReq,
  input  logic         UpdateEn,
  input  logic [k-1:0] UpdateIdx,
  input  logic [1:0]   UpdateData,
  output logic         WriteEn,
  output logic [k-1:0] WriteIdx,
  output logic [1:0]   WriteData,
  output logic         Busy,
  output logic         ClearDone,
  output logic         DropUpdate
);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_n;
  logic [k-1:0] count;
  logic last, clr;
  assign clr  = state == CLEAR;
  assign last = count == {k{1'b1}};
  always_ff @(posedge clk)
    if (reset) begin
      state     <= CLEAR;
      count     <= '0;
      ClearDone <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= clr ? count + 1'b1 : '0;
      ClearDone <= clr && last;
    end
  // a request during CLEAR is ignored: dropped updates keep cleared entries valid
  always_comb begin
    state_n    = state;
    state_n    = clr ? (last ? IDLE : CLEAR) : (ClearReq ? CLEAR : IDLE);
    WriteEn    = clr | UpdateEn;
    WriteIdx   = clr ? count : UpdateIdx;
    WriteData  = clr ? INIT_STATE : UpdateData;
    Busy       = clr;
    DropUpdate = clr & UpdateEn;
  end
endmodule

// File: tb/tb_bht_clear_sequencer.sv
// tb_bht_clear_sequencer: directed scoreboard bench with a 16x2 BHT model (k=4)
module tb_bht_clear_sequencer;
  localparam logic [1:0] INIT = 2'b01;
  logic clk = 0, reset, ClearReq, UpdateEn;
  logic [3:0] UpdateIdx, WriteIdx;
  logic [1:0] UpdateData, WriteData;
  logic WriteEn, Busy, ClearDone, DropUpdate;
  bht_clear_sequencer #(.k(4), .INIT_STATE(INIT)) dut (
    .clk(clk), .reset(reset), .ClearReq(ClearReq), .UpdateEn(UpdateEn),
    .UpdateIdx(UpdateIdx), .UpdateData(UpdateData), .WriteEn(WriteEn),
    .WriteIdx(WriteIdx), .WriteData(WriteData), .Busy(Busy),
    .ClearDone(ClearDone), .DropUpdate(DropUpdate));
  always #5 clk = ~clk;
  int tests = 0, fails = 0, done_cnt = 0, busy_cnt = 0;
  logic [1:0] bht [16];
  logic [9:0] sb [$];
  logic m_clear = 0, m_done = 0;
  logic [3:0] m_cnt = 0;
  task automatic check(input string tag, input logic [9:0] o, input logic [9:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic cyc(input logic r, input logic cr, input logic ue, input logic [3:0] ui,
                     input logic [1:0] ud, input bit chk = 1);
    logic [9:0] e, o;
    reset = r; ClearReq = cr; UpdateEn = ue; UpdateIdx = ui; UpdateData = ud;
    e = m_clear ? {1'b1, m_cnt, INIT, 1'b1, m_done, ue} : {ue, ui, ud, 1'b0, m_done, 1'b0};
    if (chk) sb.push_back(e);
    if (r) begin
      m_clear = 1; m_cnt = 0; m_done = 0;
    end else if (m_clear) begin
      m_done = m_cnt == 4'hf;
      if (m_cnt == 4'hf) m_clear = 0;
      m_cnt = m_cnt + 1;
    end else begin
      m_done = 0;
      if (cr) begin m_clear = 1; m_cnt = 0; end
    end
    @(negedge clk);
    o = {WriteEn, WriteIdx, WriteData, Busy, ClearDone, DropUpdate};
    if (chk) begin
      check("port", o, sb.pop_front());
      if (WriteEn) bht[WriteIdx] = WriteData;
      if (ClearDone) done_cnt++;
      if (Busy) busy_cnt++;
    end
    @(posedge clk); #1;
  endtask
  task automatic table_all(input string tag);
    for (int i = 0; i < 16; i++) check(tag, {8'd0, bht[i]}, {8'd0, INIT});
  endtask
  initial begin
    for (int i = 0; i < 16; i++) bht[i] = 2'bxx;
    @(posedge clk); #1;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    // 1: power-up clear
    for (int i = 0; i < 17; i++) cyc(0, 0, 0, 0, 0);
    check("reset_busy16", 10'(busy_cnt), 10'd16);
    check("reset_done1", 10'(done_cnt), 10'd1);
    table_all("reset_table");
    // 2: idle pass-through
    cyc(0, 0, 1, 5, 2'b11);
    check("upd_entry5", {8'd0, bht[5]}, 10'b11);
    // 3/4/5: request with simultaneous update, drop at 7, ignored request at 10
    cyc(0, 1, 1, 9, 2'b10);
    check("req_entry9", {8'd0, bht[9]}, 10'b10);
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 10; i++) cyc(0, 0, i == 7, 12, 2'b11);
    busy_cnt = 0;
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0);
    check("noretrig_busy6", 10'(busy_cnt), 10'd6);
    check("noretrig_done1", 10'(done_cnt), 10'd1);
    check("clr_entry5", {8'd0, bht[5]}, {8'd0, INIT});
    check("clr_entry9", {8'd0, bht[9]}, {8'd0, INIT});
    check("drop_entry12", {8'd0, bht[12]}, {8'd0, INIT});
    // 6: reset mid-clear at Count=8
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 18; i++) cyc(0, 0, i == 3, 4'(i), 2'b00);
    check("rst_busy16", 10'(busy_cnt), 10'd16);
    check("rst_done1", 10'(done_cnt), 10'd1);
    table_all("rst_table");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
